perm_engine: RTL and testbench

Parametrised, pipelined bit-permutation engine for the crypto datapath. It generalises the fixed DES P-box into a runtime-programmable WIDTH-bit permutation, and runs in forward or inverse mode per word. Typical uses are the DES P-function, IP and IP⁻¹, and any other fixed transposition the cipher cores need. It sits between the round-function combiner and the round register, with valid/ready handshakes on both sides.

---
 rtl/perm_engine_if.sv | 33 +++
 rtl/perm_engine.sv | 101 ++++++++++
 tb/tb_perm_engine.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/perm_engine_if.sv
// Handshake bundle for perm_engine: table configuration port, input word stream and output word stream.
// The slave modport is the engine's view, the master modport is the driver's view.
interface perm_engine_if #(
   parameter int WIDTH = 32
);
   localparam int IDXW = $clog2(WIDTH);

   logic              cfg_we;
   logic [IDXW-1:0]   cfg_idx;
   logic [IDXW-1:0]   cfg_src;
   logic              cfg_ready;
   logic              table_ok;

   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_data;
   logic              in_inv;

   logic              out_valid;
   logic              out_ready;
   logic [WIDTH-1:0]  out_data;
   logic              out_err;

   modport slave (
      input  cfg_we, cfg_idx, cfg_src, in_valid, in_data, in_inv, out_ready,
      output cfg_ready, table_ok, in_ready, out_valid, out_data, out_err
   );

   modport master (
      output cfg_we, cfg_idx, cfg_src, in_valid, in_data, in_inv, out_ready,
      input  cfg_ready, table_ok, in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/perm_engine.sv
// Runtime-programmable WIDTH-bit permutation with forward/inverse mode and a two-stage
// valid/ready pipeline. Table writes are only taken while the pipeline is empty.
module perm_engine #(
   parameter int WIDTH = 32,
   parameter int IDXW  = $clog2(WIDTH)
) (
   input  logic         clk,
   input  logic         rst_n,
   perm_engine_if.slave bus
);

   localparam logic [IDXW:0] LIMIT = (IDXW + 1)'(WIDTH);

   logic [IDXW-1:0]  map      [WIDTH];
   logic [IDXW-1:0]  map_next [WIDTH];
   logic [WIDTH-1:0] hit;
   logic             table_ok;

   logic             s1_valid, s1_inv;
   logic [WIDTH-1:0] s1_data;
   logic             s2_valid, s2_err;
   logic [WIDTH-1:0] s2_data;

   logic             s1_adv, s2_adv, in_ready, cfg_ready, cfg_fire, src_in_range;
   logic [WIDTH-1:0] fwd_data, inv_data;

   assign s2_adv       = !s2_valid || bus.out_ready;
   assign s1_adv       = !s1_valid || s2_adv;
   assign in_ready     = s1_adv && !bus.cfg_we;
   assign cfg_ready    = !s1_valid && !s2_valid;
   assign cfg_fire     = bus.cfg_we && cfg_ready;
   assign src_in_range = {1'b0, bus.cfg_src} < LIMIT;

   // Out-of-range cfg_idx matches no entry in the loop, so such a write is dropped naturally.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      map_next = map;
      if (cfg_fire && src_in_range) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (bus.cfg_idx == IDXW'(i)) map_next[i] = bus.cfg_src;
         end
      end
   end

   always_comb begin
      hit = '0;
      for (int k = 0; k < WIDTH; k++) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (map_next[i] == IDXW'(k)) hit[k] = 1'b1;
         end
      end
   end

   // Inverse is a scatter-OR, so a non-bijective table yields merged or missing bits.
   always_comb begin
      fwd_data = '0;
      inv_data = '0;
      for (int i = 0; i < WIDTH; i++) begin
         fwd_data[i]      = s1_data[map[i]];
         inv_data[map[i]] = inv_data[map[i]] | s1_data[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // NOTE: the table is a small register array that must come up as identity, so it is reset.
         for (int i = 0; i < WIDTH; i++) map[i] <= IDXW'(i);
         table_ok <= 1'b1;
         s1_valid <= 1'b0;
         s1_inv   <= 1'b0;
         s1_data  <= '0;
         s2_valid <= 1'b0;
         s2_err   <= 1'b0;
         s2_data  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         map      <= map_next;
         table_ok <= &hit;
         if (s1_adv) begin
            s1_valid <= bus.in_valid && in_ready;
            s1_data  <= bus.in_data;
            s1_inv   <= bus.in_inv;
         end
         if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
               s2_data <= s1_inv ? inv_data : fwd_data;
               s2_err  <= s1_inv && !table_ok;
            end
         end
      end
   end

   assign bus.cfg_ready = cfg_ready;
   assign bus.table_ok  = table_ok;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid;
   assign bus.out_data  = s2_data;
   assign bus.out_err   = s2_err;

endmodule

// File: tb/tb_perm_engine.sv
// Directed self-checking bench for perm_engine: identity, DES P table, backpressure,
// non-bijective table, config arbitration and mid-stream reset.
module tb_perm_engine;
   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   perm_engine_if #(.WIDTH(WIDTH)) bus ();

   perm_engine #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   int des_p [32] = '{15, 6, 19, 20, 28, 11, 27, 16, 0, 14, 22, 25, 4, 17, 30, 9,
                      1, 7, 23, 13, 31, 26, 2, 8, 18, 12, 29, 5, 21, 10, 3, 24};

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic cfg_write(input int idx, input int src);
      @(negedge clk);
      bus.cfg_we  = 1'b1;
      bus.cfg_idx = 5'(idx);
      bus.cfg_src = 5'(src);
      #1;
      check("cfg_ready", 64'(bus.cfg_ready), 64'd1);
   endtask

   task automatic cfg_done();
      @(negedge clk);
      bus.cfg_we = 1'b0;
   endtask

   task automatic send(input logic [31:0] data, input logic inv, input logic [31:0] exp,
                       input logic exp_err, input string tag);
      int waited;
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = data;
      bus.in_inv    = inv;
      #1;
      check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      waited = 0;
      while (!bus.out_valid && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      check({tag, "_latency"}, 64'(waited), 64'd1);
      check({tag, "_data"}, 64'(bus.out_data), 64'(exp));
      check({tag, "_err"}, 64'(bus.out_err), 64'(exp_err));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] words [8];
      logic        pat   [4];
      int          sent, recv, occ;
      logic        acc, dlv;

      bus.cfg_we    = 1'b0;
      bus.cfg_idx   = '0;
      bus.cfg_src   = '0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_inv    = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_out_data", 64'(bus.out_data), 64'd0);
      check("rst_out_err", 64'(bus.out_err), 64'd0);
      check("rst_table_ok", 64'(bus.table_ok), 64'd1);
      check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd1);

      // Identity after reset
      send(32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, "ident_fwd");

      // Back-to-back stream under out_ready pattern 1,0,0,1
      for (int i = 0; i < 8; i++) words[i] = 32'h1000_0000 + 32'(i) * 32'h0111_1111;
      pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
      sent = 0; recv = 0; occ = 0;
      @(negedge clk);
      for (int cyc = 0; cyc < 200 && recv < 8; cyc++) begin
         bus.out_ready = pat[cyc % 4];
         bus.in_valid  = (sent < 8);
         bus.in_data   = (sent < 8) ? words[sent] : 32'h0;
         bus.in_inv    = 1'b0;
         #1;
         check("bp_in_ready", 64'(bus.in_ready), 64'(occ < 2 || bus.out_ready));
         acc = bus.in_valid && bus.in_ready;
         dlv = bus.out_valid && bus.out_ready;
         if (dlv) begin
            check("bp_out_data", 64'(bus.out_data), 64'(words[recv]));
            recv++;
         end
         if (acc) sent++;
         occ = occ + int'(acc) - int'(dlv);
         @(negedge clk);
      end
      check("bp_received", 64'(recv), 64'd8);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // Non-bijective table from identity
      cfg_write(0, 1);
      cfg_done();
      check("nb_table_ok", 64'(bus.table_ok), 64'd0);
      send(32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, "nb_fwd");
      send(32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, "nb_inv");

      // Config arbitration against a held word (table still has map[0]=1)
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h0000_0005;
      bus.in_inv    = 1'b0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("arb_held_valid", 64'(bus.out_valid), 64'd1);
      bus.cfg_we   = 1'b1;
      bus.cfg_idx  = 5'd0;
      bus.cfg_src  = 5'd0;
      bus.in_valid = 1'b1;
      bus.in_data  = 32'h0000_FFFF;
      #1;
      check("arb_cfg_blocked", 64'(bus.cfg_ready), 64'd0);
      check("arb_in_blocked", 64'(bus.in_ready), 64'd0);
      repeat (2) @(negedge clk);
      check("arb_out_stable_valid", 64'(bus.out_valid), 64'd1);
      check("arb_out_stable_data", 64'(bus.out_data), 64'h4);
      check("arb_table_unchanged", 64'(bus.table_ok), 64'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("arb_drained", 64'(bus.out_valid), 64'd0);
      check("arb_cfg_ready", 64'(bus.cfg_ready), 64'd1);
      check("arb_cfg_wins", 64'(bus.in_ready), 64'd0);
      @(negedge clk);
      bus.cfg_we   = 1'b0;
      bus.in_valid = 1'b0;
      check("arb_write_taken", 64'(bus.table_ok), 64'd1);
      check("arb_no_leak", 64'(bus.out_valid), 64'd0);
      send(32'h0000_0003, 1'b1, 32'h0000_0003, 1'b0, "arb_ident_inv");

      // DES P table
      for (int i = 0; i < 32; i++) cfg_write(i, des_p[i]);
      cfg_done();
      check("des_table_ok", 64'(bus.table_ok), 64'd1);
      send(32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, "des_fwd_bit0");
      send(32'h0100_0000, 1'b0, 32'h8000_0000, 1'b0, "des_fwd_bit24");
      send(32'h0000_0100, 1'b1, 32'h0000_0001, 1'b0, "des_inv_bit8");

      // Mid-stream reset with two words in flight
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h0000_0001;
      bus.in_inv    = 1'b0;
      @(negedge clk);
      bus.in_data = 32'h0000_0002;
      @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("mrst_out_valid", 64'(bus.out_valid), 64'd0);
      check("mrst_out_data", 64'(bus.out_data), 64'd0);
      check("mrst_table_ok", 64'(bus.table_ok), 64'd1);
      check("mrst_cfg_ready", 64'(bus.cfg_ready), 64'd1);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("mrst_no_output", 64'(bus.out_valid), 64'd0);
      end
      send(32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, "mrst_ident_fwd");
      send(32'h0000_0100, 1'b1, 32'h0000_0100, 1'b0, "mrst_ident_inv");

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
